// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared state encodings for the polyphonic ADSR envelope generator
package adsr_pkg;

   localparam int STW = 3;

   typedef enum logic [STW-1:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_state_t;

   // Codes 5..7 never get written, but a corrupted register must still fall back to IDLE.
   function automatic adsr_state_t decode_state(input logic [STW-1:0] code);
      return (code > 3'd4) ? ST_IDLE : adsr_state_t'(code);
   endfunction

endpackage

// File: rtl/adsr_step.sv
// rtl/adsr_step.sv - combinational next-level/next-state step for one voice update
module adsr_step
   import adsr_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int RETRIG = 0
) (
   input  logic             gate,
   input  logic             gate_q,
   input  logic [WIDTH-1:0] level,
   input  logic [STW-1:0]   state,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] next_level,
   output logic [STW-1:0]   next_state
);

   localparam logic [WIDTH-1:0] MAX = '1;

   adsr_state_t      st;
   logic [WIDTH-1:0] lv;
   logic [WIDTH:0]   diff;
   logic             active;

   always_comb begin
      st     = decode_state(state);
      lv     = level;
      diff   = '0;
      active = (st == ST_ATTACK) || (st == ST_DECAY) || (st == ST_SUSTAIN);

      // Gate handling picks the state whose rate step is applied below.
      if (!gate && active) begin
         st = ST_RELEASE;
      end else if (gate && (!active || !gate_q)) begin
         st = ST_ATTACK;
         if (RETRIG != 0) lv = '0;
      end

      case (st)
         ST_ATTACK: begin
            if ((a == '0) || (lv >= MAX - a)) begin
               lv = MAX;
               st = ST_DECAY;
            end else begin
               lv = lv + a;
            end
         end
         ST_DECAY: begin
            // One extra bit keeps level-D signed so it cannot wrap below zero.
            diff = {1'b0, lv} - {1'b0, d};
            if ((d == '0) || ($signed(diff) <= $signed({1'b0, s}))) begin
               lv = s;
               st = ST_SUSTAIN;
            end else begin
               lv = lv - d;
            end
         end
         ST_SUSTAIN: lv = s;
         ST_RELEASE: begin
            if ((r == '0) || (lv <= r)) begin
               lv = '0;
               st = ST_IDLE;
            end else begin
               lv = lv - r;
            end
         end
         default: begin
            lv = '0;
            st = ST_IDLE;
         end
      endcase

      next_level = lv;
      next_state = st;
   end

endmodule

// File: rtl/adsr_poly.sv
// rtl/adsr_poly.sv - time-multiplexed NCH-voice ADSR envelope generator with shared controls
module adsr_poly
   import adsr_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NCH    = 8,
   parameter  int RETRIG = 0,
   localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NCH-1:0]     GATE,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   D,
   input  logic [WIDTH-1:0]   S,
   input  logic [WIDTH-1:0]   R,
   output logic [NCH*WIDTH-1:0] sout,
   output logic [3*NCH-1:0]   state,
   output logic [CW-1:0]      slot
);

   logic [WIDTH-1:0] level_r [NCH];
   logic [STW-1:0]   state_r [NCH];
   logic [NCH-1:0]   gate_q_r;

   logic [WIDTH-1:0] nxt_level;
   logic [STW-1:0]   nxt_state;

   adsr_step #(
      .WIDTH  (WIDTH),
      .RETRIG (RETRIG)
   ) u_step (
      .gate       (GATE[slot]),
      .gate_q     (gate_q_r[slot]),
      .level      (level_r[slot]),
      .state      (state_r[slot]),
      .a          (A),
      .d          (D),
      .s          (S),
      .r          (R),
      .next_level (nxt_level),
      .next_state (nxt_state)
   );

   // Only the voice addressed by slot is written; every other voice holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            level_r[i] <= '0;
            state_r[i] <= ST_IDLE;
         end
         gate_q_r <= '0;
         slot     <= '0;
      end else if (en) begin
         level_r[slot]  <= nxt_level;
         state_r[slot]  <= nxt_state;
         gate_q_r[slot] <= GATE[slot];
         slot           <= (slot == CW'(NCH - 1)) ? '0 : slot + CW'(1);
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_out
      assign sout[i*WIDTH +: WIDTH] = level_r[i];
      assign state[i*STW +: STW]    = state_r[i];
   end

endmodule

// File: tb/tb_adsr_poly.sv
// tb/tb_adsr_poly.sv - directed self-checking bench for adsr_poly (WIDTH=8, NCH=4)
module tb_adsr_poly;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b1;
   logic [3:0]  gate = 4'h0;
   logic [7:0]  a = 8'd64, d = 8'd16, s = 8'd128, r = 8'd32;
   logic [31:0] sout, sout_rt;
   logic [11:0] state, state_rt;
   logic [1:0]  slot, slot_rt;

   int n_cmp = 0;
   int n_bad = 0;

   adsr_poly #(.WIDTH(8), .NCH(4), .RETRIG(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .GATE(gate),
      .A(a), .D(d), .S(s), .R(r),
      .sout(sout), .state(state), .slot(slot)
   );

   adsr_poly #(.WIDTH(8), .NCH(4), .RETRIG(1)) dut_rt (
      .clk(clk), .rst_n(rst_n), .en(en), .GATE(gate),
      .A(a), .D(d), .S(s), .R(r),
      .sout(sout_rt), .state(state_rt), .slot(slot_rt)
   );

   always #10 clk = ~clk;

   function automatic logic [7:0] lv(input int v);
      return sout[v*8 +: 8];
   endfunction
   function automatic logic [2:0] st(input int v);
      return state[v*3 +: 3];
   endfunction
   function automatic logic [7:0] lv_rt(input int v);
      return sout_rt[v*8 +: 8];
   endfunction
   function automatic logic [2:0] st_rt(input int v);
      return state_rt[v*3 +: 3];
   endfunction

   // Advance to just after the next enabled edge that updates voice v.
   task automatic wait_update(input int v);
      int n = 0;
      while (slot !== 2'(v) && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_slot%0d: slot=%0d never reached %0d", v, slot, v);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #3;
      n_cmp++; if (sout !== 32'h0) begin n_bad++; $display("FAIL reset_sout: got %h want 0", sout); end
      n_cmp++; if (state !== 12'h0) begin n_bad++; $display("FAIL reset_state: got %h want 0", state); end
      n_cmp++; if (slot !== 2'd0) begin n_bad++; $display("FAIL reset_slot: got %0d want 0", slot); end
      n_cmp++; if (sout_rt !== 32'h0) begin n_bad++; $display("FAIL reset_sout_rt: got %h want 0", sout_rt); end
      n_cmp++; if (state_rt !== 12'h0) begin n_bad++; $display("FAIL reset_state_rt: got %h want 0", state_rt); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_envelope();
      int e_lv[12];
      int e_st[12];
      int r_lv[4];
      int r_st[4];
      e_lv = '{64, 128, 192, 255, 239, 223, 207, 191, 175, 159, 143, 128};
      e_st = '{1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3};
      r_lv = '{96, 64, 32, 0};
      r_st = '{4, 4, 4, 0};
      gate = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         wait_update(0);
         n_cmp++; if (lv(0) !== 8'(e_lv[i])) begin n_bad++; $display("FAIL env_lv[%0d]: got %0d want %0d", i, lv(0), e_lv[i]); end
         n_cmp++; if (st(0) !== 3'(e_st[i])) begin n_bad++; $display("FAIL env_st[%0d]: got %0d want %0d", i, st(0), e_st[i]); end
      end
      gate = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         wait_update(0);
         n_cmp++; if (lv(0) !== 8'(r_lv[i])) begin n_bad++; $display("FAIL rel_lv[%0d]: got %0d want %0d", i, lv(0), r_lv[i]); end
         n_cmp++; if (st(0) !== 3'(r_st[i])) begin n_bad++; $display("FAIL rel_st[%0d]: got %0d want %0d", i, st(0), r_st[i]); end
      end
      n_cmp++; if (sout[31:8] !== 24'h0) begin n_bad++; $display("FAIL env_others: got %h want 0", sout[31:8]); end
   endtask

   task automatic test_early_release();
      gate = 4'b0001;
      wait_update(0);
      wait_update(0);
      n_cmp++; if (lv(0) !== 8'd128 || st(0) !== 3'd1) begin n_bad++; $display("FAIL early_pre: got %0d/%0d want 128/1", lv(0), st(0)); end
      gate = 4'b0000;
      wait_update(0);
      n_cmp++; if (lv(0) !== 8'd96 || st(0) !== 3'd4) begin n_bad++; $display("FAIL early_rel: got %0d/%0d want 96/4", lv(0), st(0)); end
      n_cmp++; if (lv_rt(0) !== 8'd96 || st_rt(0) !== 3'd4) begin n_bad++; $display("FAIL early_rel_rt: got %0d/%0d want 96/4", lv_rt(0), st_rt(0)); end
      wait_update(0);
      n_cmp++; if (lv(0) !== 8'd64 || st(0) !== 3'd4) begin n_bad++; $display("FAIL early_rel2: got %0d/%0d want 64/4", lv(0), st(0)); end
   endtask

   task automatic test_retrigger();
      gate = 4'b0001;
      wait_update(0);
      n_cmp++; if (lv(0) !== 8'd128 || st(0) !== 3'd1) begin n_bad++; $display("FAIL retrig0: got %0d/%0d want 128/1", lv(0), st(0)); end
      n_cmp++; if (lv_rt(0) !== 8'd64 || st_rt(0) !== 3'd1) begin n_bad++; $display("FAIL retrig1: got %0d/%0d want 64/1", lv_rt(0), st_rt(0)); end
      gate = 4'b0000;
      for (int i = 0; i < 5; i++) wait_update(0);
      n_cmp++; if (lv(0) !== 8'd0 || st(0) !== 3'd0) begin n_bad++; $display("FAIL retrig_idle: got %0d/%0d want 0/0", lv(0), st(0)); end
      n_cmp++; if (lv_rt(0) !== 8'd0 || st_rt(0) !== 3'd0) begin n_bad++; $display("FAIL retrig_idle_rt: got %0d/%0d want 0/0", lv_rt(0), st_rt(0)); end
   endtask

   task automatic test_zero_rates();
      a = 8'd0; d = 8'd0; r = 8'd0;
      gate = 4'b0100;
      wait_update(2);
      n_cmp++; if (lv(2) !== 8'd255 || st(2) !== 3'd2) begin n_bad++; $display("FAIL zero_att: got %0d/%0d want 255/2", lv(2), st(2)); end
      wait_update(2);
      n_cmp++; if (lv(2) !== 8'd128 || st(2) !== 3'd3) begin n_bad++; $display("FAIL zero_dec: got %0d/%0d want 128/3", lv(2), st(2)); end
      gate = 4'b0000;
      wait_update(2);
      n_cmp++; if (lv(2) !== 8'd0 || st(2) !== 3'd0) begin n_bad++; $display("FAIL zero_rel: got %0d/%0d want 0/0", lv(2), st(2)); end
      a = 8'd64; d = 8'd16; r = 8'd32;
   endtask

   task automatic test_en();
      int e_en[11];
      int e_slot[11];
      int e_lv[11];
      e_en   = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 1};
      e_slot = '{1, 1, 2, 2, 2, 3, 0, 1, 1, 2, 3};
      e_lv   = '{64, 64, 64, 64, 64, 64, 64, 128, 128, 128, 128};
      gate = 4'b0001;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      n_cmp++; if (slot !== 2'd0) begin n_bad++; $display("FAIL en_start_slot: got %0d want 0", slot); end
      for (int i = 0; i < 11; i++) begin
         en = e_en[i][0];
         @(negedge clk);
         n_cmp++; if (slot !== 2'(e_slot[i])) begin n_bad++; $display("FAIL en_slot[%0d]: got %0d want %0d", i, slot, e_slot[i]); end
         n_cmp++; if (lv(0) !== 8'(e_lv[i])) begin n_bad++; $display("FAIL en_lv[%0d]: got %0d want %0d", i, lv(0), e_lv[i]); end
      end
      en = 1'b1;
   endtask

   task automatic test_async_reset();
      wait_update(0);
      wait_update(0);
      wait_update(0);
      n_cmp++; if (lv(0) !== 8'd239 || st(0) !== 3'd2) begin n_bad++; $display("FAIL ar_pre: got %0d/%0d want 239/2", lv(0), st(0)); end
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (sout !== 32'h0) begin n_bad++; $display("FAIL ar_sout: got %h want 0", sout); end
      n_cmp++; if (state !== 12'h0) begin n_bad++; $display("FAIL ar_state: got %h want 0", state); end
      n_cmp++; if (slot !== 2'd0) begin n_bad++; $display("FAIL ar_slot: got %0d want 0", slot); end
      gate = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_live_sustain();
      gate = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (lv(k) !== 8'd64) begin n_bad++; $display("FAIL sim_first[%0d]: got %0d want 64", k, lv(k)); end
         if (k < 3) begin
            n_cmp++; if (lv(k+1) !== 8'd0) begin n_bad++; $display("FAIL sim_wait[%0d]: got %0d want 0", k+1, lv(k+1)); end
         end
      end
      repeat (40) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (lv(k) !== 8'd128 || st(k) !== 3'd3) begin n_bad++; $display("FAIL sus_reach[%0d]: got %0d/%0d want 128/3", k, lv(k), st(k)); end
         if (k < 3) begin
            n_cmp++; if (lv(k+1) !== 8'd143 || st(k+1) !== 3'd2) begin n_bad++; $display("FAIL sus_order[%0d]: got %0d/%0d want 143/2", k+1, lv(k+1), st(k+1)); end
         end
      end
      s = 8'd200;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (lv(k) !== 8'd200 || st(k) !== 3'd3) begin n_bad++; $display("FAIL live_s[%0d]: got %0d/%0d want 200/3", k, lv(k), st(k)); end
         if (k < 3) begin
            n_cmp++; if (lv(k+1) !== 8'd128) begin n_bad++; $display("FAIL live_s_hold[%0d]: got %0d want 128", k+1, lv(k+1)); end
         end
      end
      gate = 4'b0000;
      s = 8'd128;
   endtask

   initial begin
      test_reset();
      test_full_envelope();
      test_early_release();
      test_retrigger();
      test_zero_rates();
      test_en();
      test_async_reset();
      test_live_sustain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adsr_poly.md
# adsr_poly

Parametrised, time-multiplexed ADSR envelope generator for NCH voices sharing one set of A/D/S/R controls. It generalises the single-voice 32-bit adsr32 into a WIDTH-bit, NCH-channel block with per-voice GATE, a clock-enable sample tick and a selectable retrigger mode. One shared update datapath serves voices round-robin. It sits between the note/gate allocator and the per-voice VCA multipliers.

## Interface
- WIDTH, 32: envelope level and rate width; full scale MAX = 2^WIDTH-1
- NCH, 8: number of voices, must be ≥ 2
- RETRIG, 0: 0 = re-attack continues from the current level; 1 = re-attack restarts from 0
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  update enable; the slot counter advances and a voice updates only when high
- GATE  in  NCH  per-voice gate, bit i = voice i
- A  in  WIDTH  attack increment per voice update; 0 = instantaneous
- D  in  WIDTH  decay decrement per voice update; 0 = instantaneous
- S  in  WIDTH  sustain level
- R  in  WIDTH  release decrement per voice update; 0 = instantaneous
- sout  out  NCH*WIDTH  envelope levels, voice i at [i*WIDTH +: WIDTH]
- state  out  3*NCH  voice states, voice i at [i*3 +: 3]
- slot  out  CW = max(1,clog2(NCH))  index of the voice updated at the next enabled edge

## Operation
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5–7 are illegal and decode as IDLE.
- On each rising clk edge with en=1, voice v=slot alone is updated: its GATE bit is sampled, then next state/level are computed. slot then increments, wrapping NCH-1 → 0.
- Per-voice registers: level, state, gate_q (GATE sampled at the previous update).
- Gate rules, evaluated before the rate step. Rate steps use the resulting state.
  - GATE=0 in ATTACK, DECAY or SUSTAIN → RELEASE.
  - GATE=1 in IDLE or RELEASE → ATTACK; level reset to 0 if RETRIG=1.
  - Rising edge (GATE=1, gate_q=0) in ATTACK, DECAY or SUSTAIN → ATTACK; level reset to 0 only if RETRIG=1.
- Rate steps:
  - ATTACK: if A=0 or level ≥ MAX−A, level=MAX and state→DECAY; else level+=A.
  - DECAY: if D=0 or level−D ≤ S, computed WIDTH+1 signed, then level=S and state→SUSTAIN; else level−=D.
  - SUSTAIN: level=S, tracking live changes of S.
  - RELEASE: if R=0 or level ≤ R, level=0 and state→IDLE; else level−=R.
  - IDLE: level=0.
- Saturation: no wrap-around is permitted in any state.
- A/D/S/R are sampled at each voice's own update. Changing them mid-envelope affects only subsequent updates.

## Timing
- Reset values: all sout=0, all state=IDLE, all gate_q=0, slot=0.
- Reset is asynchronous. Asserting it mid-envelope clears every voice immediately, with no release tail.
- Latency: a GATE change on voice v is seen at the first enabled edge where slot=v. sout and state reflect it after that edge, within at most NCH enabled cycles.
- Each voice updates once per NCH enabled cycles. en=0 freezes all registers, including slot.
- Outputs are registered. No combinational path runs from inputs to outputs.
- A GATE pulse shorter than one full slot rotation may be missed; this is by design.

## Structure
- adsr_pkg: state encodings (ST_IDLE…ST_RELEASE) and the 3-bit state width constant.
- Sub-module adsr_step (combinational): inputs gate, gate_q, level, state, A/D/S/R and RETRIG; outputs next level and state. It is instantiated once and fed by a mux selected by slot.
- adsr_poly holds the slot counter, the per-voice register arrays and the write-back decode.

## Test plan
Default configuration for all scenarios: WIDTH=8, NCH=4, RETRIG=0, A=64, D=16, S=128, R=32, en=1; values are read every 4 cycles.

- Full envelope, voice 0: GATE[0]=1 → sout0 = 64, 128, 192, 255 (DECAY), then 239, 223, 207, 191, 175, 159, 143, 128 (SUSTAIN). Drop GATE[0] → 96, 64, 32, 0 (IDLE). Voices 1–3 stay at 0.
- Early release: drop GATE[0] while level = 128 in ATTACK → next voice-0 update gives 96 in RELEASE.
- Retrigger mode: in RELEASE at 64, GATE[0] low→high.
  - RETRIG=0 → 128 in ATTACK.
  - RETRIG=1 → 64 in ATTACK, i.e. restarted from 0 and then stepped by A.
- Zero rates: A=D=R=0, GATE[2]=1 → sout2=255 then 128. GATE[2]=0 → 0 on the next update.
- en and rst_n:
  - en toggled 1/0 → slot and sout advance only on en=1 edges.
  - rst_n low mid-DECAY → sout, state and slot are 0 immediately, before the next clk edge.
- Live sustain and simultaneous gates: all four GATE bits rise together → voices step in slot order 0..3, each reaching SUSTAIN on its own slot. Changing S to 200 while in SUSTAIN → each sout=200 at that voice's next update.
